key_event_queue: RTL and testbench

- Sits between KeyboardDecoder and the typing counter (count).
- Converts the raw PS/2 decoder outputs (key_valid pulse, last_change scancode, key_down bitmap) into a clean stream of 5-bit character events: letters, space, backspace and enter.
- Suppresses typematic auto-repeat and buffers events in a small FIFO with a valid/ready handshake, so the counter consumes at most one keystroke per cycle and never misses a burst.

---
 rtl/typer_pkg.sv | 15 +
 rtl/scan_to_code.sv | 48 ++++
 rtl/key_event_queue.sv | 108 ++++++++++
 tb/tb_key_event_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/typer_pkg.sv
// Shared definitions for the typing-game keyboard path.
//   - 5-bit event codes delivered to the typing counter
//   - PS/2 set-2 scancodes of the non-letter keys the game understands
package typer_pkg;

    localparam logic [4:0] EV_NONE  = 5'd0;
    localparam logic [4:0] EV_SPACE = 5'd27;
    localparam logic [4:0] EV_BKSP  = 5'd28;
    localparam logic [4:0] EV_ENTER = 5'd29;

    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ENTER = 8'h5A;

endpackage

// File: rtl/scan_to_code.sv
// Combinational PS/2 set-2 scancode -> 5-bit event code map.
// Letters map to 1..26 (lowercase only), space/backspace/enter to 27..29,
// everything else to EV_NONE. Also used by the VGA keyboard hint.
//   scancode  in   8  set-2 scancode (extended prefix stripped)
//   code      out  5  event code, EV_NONE when the key is not used
module scan_to_code
    import typer_pkg::*;
(
    input  logic [7:0] scancode,
    output logic [4:0] code
);

    always_comb begin
        case (scancode)
            8'h1C:    code = 5'd1;   // a
            8'h32:    code = 5'd2;   // b
            8'h21:    code = 5'd3;   // c
            8'h23:    code = 5'd4;   // d
            8'h24:    code = 5'd5;   // e
            8'h2B:    code = 5'd6;   // f
            8'h34:    code = 5'd7;   // g
            8'h33:    code = 5'd8;   // h
            8'h43:    code = 5'd9;   // i
            8'h3B:    code = 5'd10;  // j
            8'h42:    code = 5'd11;  // k
            8'h4B:    code = 5'd12;  // l
            8'h3A:    code = 5'd13;  // m
            8'h31:    code = 5'd14;  // n
            8'h44:    code = 5'd15;  // o
            8'h4D:    code = 5'd16;  // p
            8'h15:    code = 5'd17;  // q
            8'h2D:    code = 5'd18;  // r
            8'h1B:    code = 5'd19;  // s
            8'h2C:    code = 5'd20;  // t
            8'h3C:    code = 5'd21;  // u
            8'h2A:    code = 5'd22;  // v
            8'h1D:    code = 5'd23;  // w
            8'h22:    code = 5'd24;  // x
            8'h35:    code = 5'd25;  // y
            8'h1A:    code = 5'd26;  // z
            SC_SPACE: code = EV_SPACE;
            SC_BKSP:  code = EV_BKSP;
            SC_ENTER: code = EV_ENTER;
            default:  code = EV_NONE;
        endcase
    end

endmodule

// File: rtl/key_event_queue.sv
// Turns raw KeyboardDecoder outputs into a filtered stream of character
// events (letters, space, backspace, enter) held in a small FIFO with a
// valid/ready interface toward the typing counter.
//   clk, rst     clock, async active-high reset
//   key_valid    one-cycle pulse when last_change updates
//   last_change  set-2 scancode of the latest key event
//   key_down     held-key bitmap indexed by scancode
//   enable       accept keystrokes (game running)
//   clear        synchronous flush of FIFO, overflow and repeat filter
//   ev_ready     consumer takes the head event
//   ev_valid     FIFO non-empty
//   ev_code      head event code, 0 when empty
//   level        number of stored events
//   overflow     sticky, an event was dropped on a full FIFO
module key_event_queue
    import typer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    input  logic [7:0]    last_change,
    input  logic [127:0]  key_down,
    input  logic          enable,
    input  logic          clear,
    input  logic          ev_ready,
    output logic          ev_valid,
    output logic [4:0]    ev_code,
    output logic [AW:0]   level,
    output logic          overflow
);

    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  held_q, held_d;
    logic        ovf_q, ovf_d;
    logic [4:0]  mem_q [DEPTH];

    logic [4:0]  code;
    logic        key_hit, make, brk, repeat_hit;
    logic        empty, full, push, pop, wr_en;

    scan_to_code u_map (
        .scancode (last_change),
        .code     (code)
    );

    // Scancodes with bit 7 set cannot index the bitmap and are ignored.
    assign key_hit    = key_down[last_change[6:0]];
    assign make       = key_valid & ~last_change[7] & key_hit;
    assign brk        = key_valid & ~last_change[7] & ~key_hit;
    assign repeat_hit = (last_change == held_q);

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign push  = make & (code != EV_NONE) & ~repeat_hit & enable & ~clear;
    assign pop   = ~empty & ev_ready & ~clear;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        ovf_d  = ovf_q;
        held_d = held_q;
        if (clear) begin
            wr_d   = '0;
            rd_d   = '0;
            ovf_d  = 1'b0;
            held_d = '0;
        end else begin
            if (wr_en)                wr_d  = wr_q + (AW+1)'(1);
            if (pop)                  rd_d  = rd_q + (AW+1)'(1);
            if (push & full & ~pop)   ovf_d = 1'b1;
            // Filter tracks make/break even when pushes are blocked.
            if (make & ~repeat_hit)       held_d = last_change;
            else if (brk & repeat_hit)    held_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            held_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            ovf_q  <= ovf_d;
            held_q <= held_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= code;
    end

    assign ev_valid = ~empty;
    assign ev_code  = empty ? EV_NONE : mem_q[rd_q[AW-1:0]];
    assign level    = wr_q - rd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    localparam logic [7:0] LET [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

    localparam logic [7:0] POOL [12] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h1A,
        8'h29, 8'h66, 8'h5A, 8'h12, 8'h9C, 8'h0E};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          key_valid = 1'b0;
    logic [7:0]    last_change = '0;
    logic [127:0]  key_down = '0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          ev_ready = 1'b0;
    logic          ev_valid;
    logic [4:0]    ev_code;
    logic [AW:0]   level;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of event codes, held key, sticky overflow.
    int         mq[$];
    logic [7:0] mheld = '0;
    bit         movf  = 1'b0;

    key_event_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_down    (key_down),
        .enable      (enable),
        .clear       (clear),
        .ev_ready    (ev_ready),
        .ev_valid    (ev_valid),
        .ev_code     (ev_code),
        .level       (level),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int map_code(input logic [7:0] sc);
        for (int i = 0; i < 26; i++)
            if (LET[i] == sc) return i + 1;
        if (sc == 8'h29) return 27;
        if (sc == 8'h66) return 28;
        if (sc == 8'h5A) return 29;
        return 0;
    endfunction

    // Model update on every active edge / reset assertion.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                mheld = '0;
                movf  = 1'b0;
            end else if (clear) begin
                mq.delete();
                mheld = '0;
                movf  = 1'b0;
            end else begin
                bit is_make, is_brk, was_full, popped;
                int c;
                is_make  = key_valid && !last_change[7] && key_down[last_change[6:0]];
                is_brk   = key_valid && !last_change[7] && !key_down[last_change[6:0]];
                c        = map_code(last_change);
                was_full = (mq.size() == DEPTH);
                popped   = (mq.size() > 0) && ev_ready;
                if (popped) void'(mq.pop_front());
                if (is_make && c != 0 && last_change != mheld && enable) begin
                    if (!was_full || popped) mq.push_back(c);
                    else movf = 1'b1;
                end
                if (is_make && last_change != mheld) mheld = last_change;
                else if (is_brk && last_change == mheld) mheld = '0;
            end
        end
    end

    // Compare process: outputs vs model on every falling edge.
    always @(negedge clk) begin
        chk("m_valid", int'(ev_valid), int'(mq.size() != 0));
        chk("m_code", int'(ev_code), (mq.size() != 0) ? mq[0] : 0);
        chk("m_level", int'(level), mq.size());
        chk("m_ovf", int'(overflow), int'(movf));
    end

    task automatic key(input logic [7:0] sc, input logic dn);
        key_down[sc[6:0]] = dn;
        last_change = sc;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic pop1();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_code", int'(ev_code), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // single make, then consume
        key(8'h1C, 1'b1);
        chk("a_valid", int'(ev_valid), 1);
        chk("a_code", int'(ev_code), 1);
        chk("a_level", int'(level), 1);
        pop1();
        chk("a_popped_valid", int'(ev_valid), 0);
        chk("a_popped_code", int'(ev_code), 0);

        // typematic repeats collapse to one event
        key(8'h1C, 1'b0);
        repeat (3) key(8'h1C, 1'b1);
        chk("rep_level", int'(level), 1);
        key(8'h1C, 1'b0);
        key(8'h1C, 1'b1);
        chk("rep_level2", int'(level), 2);
        pop1();
        pop1();

        // shift discarded, specials in order
        key(8'h12, 1'b1);
        key(8'h29, 1'b1);
        key(8'h66, 1'b1);
        key(8'h5A, 1'b1);
        chk("sp_level", int'(level), 3);
        chk("sp_code0", int'(ev_code), 27);
        pop1();
        chk("sp_code1", int'(ev_code), 28);
        pop1();
        chk("sp_code2", int'(ev_code), 29);
        pop1();

        // overflow on the ninth letter
        for (int i = 0; i < 9; i++) key(LET[i], 1'b1);
        chk("full_level", int'(level), 8);
        chk("full_ovf", int'(overflow), 1);
        chk("full_head", int'(ev_code), 1);
        ev_ready = 1'b1;
        key(LET[9], 1'b1);
        ev_ready = 1'b0;
        chk("pp_level", int'(level), 8);
        chk("pp_head", int'(ev_code), 2);

        // disabled make, drain to 5, then clear
        enable = 1'b0;
        key(8'h2C, 1'b1);
        chk("dis_level", int'(level), 8);
        repeat (3) pop1();
        chk("drain_level", int'(level), 5);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_level", int'(level), 0);
        chk("clr_valid", int'(ev_valid), 0);
        chk("clr_ovf", int'(overflow), 0);
        enable = 1'b1;

        // async reset mid-burst
        for (int i = 0; i < 4; i++) key(LET[i], 1'b1);
        chk("burst_level", int'(level), 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", int'(ev_valid), 0);
        chk("arst_code", int'(ev_code), 0);
        chk("arst_level", int'(level), 0);
        @(negedge clk);
        rst = 1'b0;
        key(8'h1C, 1'b1);
        chk("post_rst_code", int'(ev_code), 1);
        chk("post_rst_level", int'(level), 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            enable   = ($urandom % 8) != 0;
            ev_ready = ($urandom % 3) == 0;
            clear    = ($urandom % 200) == 0;
            if ($urandom % 2) begin
                logic [7:0] sc;
                sc = POOL[$urandom % 12];
                key_down[sc[6:0]] = 1'($urandom % 2);
                last_change = sc;
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        clear = 1'b0;
        ev_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
